// File: rtl/uart_rx_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_unit
//  Purpose  : 8N1 UART receiver presenting bytes through a sticky
//             ready/data/eot flag handshake, with overrun and framing errors.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_unit #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] EOT_CODE     = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clear_flag,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       eot_out,
    output logic       overrun_err,
    output logic       frame_err
);

    localparam int                c_TW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0]   c_TICK_MID  = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TW-1:0]   c_TICK_LAST = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0]   c_TICK_ONE  = c_TW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sync;
    logic             w_rx_s;
    logic [c_TW-1:0]  r_tick;
    logic [c_TW-1:0]  w_tick_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_done;
    logic             w_ferr;
    logic             r_done;
    logic             w_clr;

    assign w_rx_s = r_sync[1];
    assign w_clr  = clear_flag & ready_out;

    // Synchroniser resets high so an idle line is not mistaken for a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_done    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_done    <= w_done;
            frame_err <= w_ferr;
        end
    end

    // Timer restarts at mid start bit, so every later LAST tick is a mid-bit sample
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick + c_TICK_ONE;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_tick == c_TICK_MID) begin
                    w_tick_nxt = '0;
                    w_bit_nxt  = 3'd0;
                    if (!w_rx_s) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt  = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (w_rx_s) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_tick_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_tick_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A completion coinciding with a clear means the old byte was consumed: no overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_out   <= 1'b0;
            data_out    <= 8'h00;
            eot_out     <= 1'b0;
            overrun_err <= 1'b0;
        end else if (r_done) begin
            data_out  <= r_shift;
            ready_out <= 1'b1;
            eot_out   <= (r_shift == EOT_CODE);
            if (w_clr) begin
                overrun_err <= 1'b0;
            end else if (ready_out) begin
                overrun_err <= 1'b1;
            end
        end else if (w_clr) begin
            ready_out   <= 1'b0;
            eot_out     <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_unit.md
# uart_rx_unit

Serial receive front-end that deserialises 8N1 UART frames from the board RX pin and presents each byte through the flag interface consumed by `Crypter`: `ready`/`data`/`eot`, cleared by the consumer's `clear_rx_flag`. It sits between the pin and the crypt datapath and is the producer side of the byte handshake that `Crypter` reads.

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per bit (100 MHz / 115200). Must be an even number ≥ 8.
- `EOT_CODE`, default 8'h04, byte value that flags end of transmission.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `clear_flag`  in  1  one-cycle clear from the consumer; connects to `clear_rx_flag`.
- `ready_out`  out  1  byte available flag, sticky until cleared; connects to `ready_in`.
- `data_out`  out  8  last received byte, held until the next good frame; connects to `data_in`.
- `eot_out`  out  1  last byte equals `EOT_CODE`, sticky with `ready_out`; connects to `eot_in`.
- `overrun_err`  out  1  sticky; a byte completed while `ready_out` was already 1.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.

## Operation
- `rx` passes through a 2-FF synchroniser, giving `rx_s`. All decisions use `rx_s`.
- Bit counter `bit_cnt` is 3 bits. Timer `tick_cnt` is sized to `CLKS_PER_BIT-1`.
- FSM states:
  - **IDLE**: on `rx_s`==0, clear the timer and go to START.
  - **START**: at timer = `CLKS_PER_BIT/2-1` (mid start bit):
    - if `rx_s`==0, restart the timer and go to DATA with `bit_cnt`=0;
    - otherwise it is a glitch; return to IDLE with no output change.
  - **DATA**: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register LSB-first. After bit 7, go to STOP.
  - **STOP**: at the next mid-bit sample:
    - if `rx_s`==1 (good frame), complete the byte and go to IDLE;
    - if `rx_s`==0, pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
  - **WAIT_IDLE**: stay until `rx_s`==1, then go to IDLE. A line held low (break) never produces a byte.
- Byte completion, registered on the cycle after the stop sample:
  - `data_out` ← shift register;
  - `ready_out` ← 1;
  - `eot_out` ← (byte == `EOT_CODE`);
  - if `ready_out` was already 1, `overrun_err` ← 1. The new byte overwrites the old one.
- `clear_flag`: `ready_out`, `eot_out` and `overrun_err` go to 0 on the next edge. `data_out` is unchanged.
- Completion and `clear_flag` in the same cycle: completion wins, so `ready_out`=1 and `eot_out` reflects the new byte. `overrun_err` is not set, because the old byte was consumed.
- `clear_flag` while `ready_out`=0 has no effect.

## Timing
- Reset values (asynchronous, `rst`=0):
  - FSM in IDLE, counters at 0, synchroniser at 1;
  - `ready_out`=0, `eot_out`=0, `overrun_err`=0, `frame_err`=0, `data_out`=8'h00.
- Reset mid-frame aborts the frame. After release the FSM waits in IDLE for a fresh falling edge; a partial byte is never emitted.
- Latency: first clk edge at which `rx` is low → `ready_out` high is 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles. The bench tolerance is ±1 cycle.
- Back-to-back frames are received with no idle gap; the FSM is in IDLE half a bit before the stop bit ends.
- `frame_err` is high for exactly one cycle.
- Outputs are registered; there are no combinational paths from `rx` or `clear_flag` to outputs.

## Test plan
Bench uses `CLKS_PER_BIT`=16 and an 8N1 task driver.

1. Send 0x68 → `ready_out`=1 at the expected cycle (±1), `data_out`=0x68, `eot_out`=0, both errors 0. Then pulse `clear_flag` → `ready_out`=0 next cycle, `data_out` still 0x68.
2. Send 0x04 → `ready_out`=1, `eot_out`=1. Then `clear_flag` → both flags 0. Send 0x65 → `eot_out`=0.
3. Send 0x68 then 0x65 back-to-back with no clear → `data_out`=0x65, `overrun_err`=1. Then `clear_flag` → `overrun_err`=0.
4. Assert `clear_flag` on the exact completion cycle of 0x6C while `ready_out`=1 → `ready_out` stays 1, `data_out`=0x6C, `overrun_err`=0.
5. Frame 0xA5 with stop bit 0, line held low 40 cycles, then 0x21 sent normally:
   - during the bad frame, one `frame_err` pulse and `ready_out` stays 0;
   - 0x21 is then received correctly.
   Also drive a 5-cycle low glitch on idle → no output change.
6. Assert `rst` low mid-DATA of 0x77 → all outputs at reset values immediately. Release `rst` and send 0x6F → `data_out`=0x6F, no spurious byte before it.
